// File: rtl/ucsbece154a_mc_controller.sv
// rtl/ucsbece154a_mc_controller.sv - multicycle RV32I-subset control FSM
//
// Sequences a shared-memory multicycle datapath (one memory port, one ALU,
// IR/OldPC/A/ALUOut/Data holding registers). Supports lw, sw, R-type ALU,
// I-type ALU, beq, jal and lui, and stalls on MemReady_i during memory
// accesses. An unsupported opcode parks the FSM in TRAP until reset.
//
// Ports:
//   clk, reset_ni           clock, asynchronous active-low reset
//   op_i, funct3_i,         instruction fields IR[6:0], IR[14:12], IR[30]
//   funct7b5_i
//   zero_i                  ALU zero flag (beq decision)
//   MemReady_i              memory completes the current access this cycle
//   PCWrite_o, IRWrite_o,   datapath register and memory enables
//   MemWrite_o, RegWrite_o
//   AdrSrc_o, ResultSrc_o,  datapath multiplexer selects
//   ALUSrcA_o, ALUSrcB_o
//   ALUControl_o            ALU operation
//   ImmSrc_o                immediate format, decoded from op_i in every state
//   Illegal_o               sticky unsupported-opcode flag
module ucsbece154a_mc_controller (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       MemReady_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALUControl_o,
  output logic       RegWrite_o,
  output logic [2:0] ImmSrc_o,
  output logic       Illegal_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = S_FETCH;
    PCWrite_o   = 1'b0;
    AdrSrc_o    = 1'b0;
    MemWrite_o  = 1'b0;
    IRWrite_o   = 1'b0;
    ResultSrc_o = 2'b00;
    ALUSrcA_o   = 2'b00;
    ALUSrcB_o   = 2'b00;
    alu_op      = 2'b00;
    RegWrite_o  = 1'b0;
    Illegal_o   = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 is computed while the instruction is read; both commit on ready
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        IRWrite_o   = MemReady_i;
        PCWrite_o   = MemReady_i;
        state_next  = MemReady_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut so beq/jal already have their target
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
        case (op_i)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_IALU:      state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          OP_LUI:       state_next = S_LUI;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
        if (op_i == OP_LW) begin
          state_next = S_MEMREAD;
        end else if (op_i == OP_SW) begin
          state_next = S_MEMWRITE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEMREAD: begin
        AdrSrc_o   = 1'b1;
        state_next = MemReady_i ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc_o = 2'b01;
        RegWrite_o  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc_o   = 1'b1;
        MemWrite_o = 1'b1;
        state_next = MemReady_i ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA_o  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA_o  = 2'b10;
        ALUSrcB_o  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite_o = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA_o = 2'b10;
        alu_op    = 2'b01;
        PCWrite_o = zero_i;
      end
      S_JAL: begin
        // PC takes the target from ALUOut; ALU forms the link value OldPC+4
        ALUSrcA_o  = 2'b01;
        ALUSrcB_o  = 2'b10;
        PCWrite_o  = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc_o = 2'b11;
        RegWrite_o  = 1'b1;
      end
      S_TRAP: begin
        Illegal_o  = 1'b1;
        state_next = S_TRAP;
      end
      default: state_next = S_FETCH;
    endcase
    // The state is already FETCH during reset, but FETCH would otherwise
    // follow MemReady_i; gate every enable so nothing commits while held.
    if (!reset_ni) begin
      PCWrite_o  = 1'b0;
      IRWrite_o  = 1'b0;
      MemWrite_o = 1'b0;
      RegWrite_o = 1'b0;
      Illegal_o  = 1'b0;
    end
  end

  always_comb begin
    ALUControl_o = 3'b000;
    case (alu_op)
      2'b00: ALUControl_o = 3'b000;
      2'b01: ALUControl_o = 3'b001;
      2'b10: begin
        case (funct3_i)
          // op_i[5] separates R-type from I-type so addi never becomes sub
          3'b000:  ALUControl_o = (funct7b5_i & op_i[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl_o = 3'b101;
          3'b110:  ALUControl_o = 3'b011;
          3'b111:  ALUControl_o = 3'b010;
          default: ALUControl_o = 3'b000;
        endcase
      end
      default: ALUControl_o = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc_o = 3'b000;
    case (op_i)
      OP_LW, OP_IALU: ImmSrc_o = 3'b000;
      OP_SW:          ImmSrc_o = 3'b001;
      OP_BEQ:         ImmSrc_o = 3'b010;
      OP_JAL:         ImmSrc_o = 3'b011;
      OP_LUI:         ImmSrc_o = 3'b100;
      default:        ImmSrc_o = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// tb/tb_ucsbece154a_mc_controller.sv - scoreboard bench for the multicycle controller
module tb_ucsbece154a_mc_controller;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BAD  = 7'b0001111;

  logic       clk;
  logic       reset_ni;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       reg_write;
  logic [2:0] imm_src;
  logic       illegal;

  ucsbece154a_mc_controller dut (
    .clk          (clk),
    .reset_ni     (reset_ni),
    .op_i         (op),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .zero_i       (zero),
    .MemReady_i   (mem_ready),
    .PCWrite_o    (pc_write),
    .AdrSrc_o     (adr_src),
    .MemWrite_o   (mem_write),
    .IRWrite_o    (ir_write),
    .ResultSrc_o  (result_src),
    .ALUSrcA_o    (alu_src_a),
    .ALUSrcB_o    (alu_src_b),
    .ALUControl_o (alu_control),
    .RegWrite_o   (reg_write),
    .ImmSrc_o     (imm_src),
    .Illegal_o    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] exp;
  } item_t;

  item_t sb_q[$];
  int    errors = 0;
  int    checks = 0;

  // {pcw, adr, mw, irw, rs[2], sa[2], sb[2], alu[3], rw, imm[3], ill}
  function automatic logic [17:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu, input logic rw,
                                     input logic [2:0] imm, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, rw, imm, ill};
  endfunction

  function automatic logic [17:0] e_rst(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, imm, 0);
  endfunction
  function automatic logic [17:0] e_fetch(input logic rdy, input logic [2:0] imm);
    return ev(rdy, 0, 0, rdy, 2'b10, 2'b00, 2'b10, 3'b000, 0, imm, 0);
  endfunction
  function automatic logic [17:0] e_dec(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 0);
  endfunction
  function automatic logic [17:0] e_memadr(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, imm, 0);
  endfunction
  function automatic logic [17:0] e_memrd(input logic [2:0] imm);
    return ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, imm, 0);
  endfunction
  function automatic logic [17:0] e_memwb(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, imm, 0);
  endfunction
  function automatic logic [17:0] e_memwr(input logic [2:0] imm);
    return ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, imm, 0);
  endfunction
  function automatic logic [17:0] e_execr(input logic [2:0] alu, input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0, imm, 0);
  endfunction
  function automatic logic [17:0] e_execi(input logic [2:0] alu, input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 0, imm, 0);
  endfunction
  function automatic logic [17:0] e_aluwb(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, imm, 0);
  endfunction
  function automatic logic [17:0] e_beq(input logic z, input logic [2:0] imm);
    return ev(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, imm, 0);
  endfunction
  function automatic logic [17:0] e_jal(input logic [2:0] imm);
    return ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, imm, 0);
  endfunction
  function automatic logic [17:0] e_lui(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b000, 1, imm, 0);
  endfunction
  function automatic logic [17:0] e_trap(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, imm, 1);
  endfunction

  // One cycle: drive inputs just after the rising edge and queue the
  // expected outputs for that cycle.
  task automatic cyc(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input logic rdy, input logic rst,
                     input string nm, input logic [17:0] e);
    item_t it;
    @(posedge clk);
    #1;
    op        = o;
    funct3    = f3;
    funct7b5  = f7;
    zero      = z;
    mem_ready = rdy;
    reset_ni  = rst;
    it.name   = nm;
    it.exp    = e;
    sb_q.push_back(it);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      item_t       it;
      logic [17:0] act;
      it  = sb_q.pop_front();
      act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
             alu_control, reg_write, imm_src, illegal};
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_ni  = 1'b0;
    op        = OP_LW;
    funct3    = 3'b000;
    funct7b5  = 1'b0;
    zero      = 1'b0;
    mem_ready = 1'b1;

    cyc(OP_LW, 3'b000, 0, 0, 1, 0, "reset0", e_rst(3'b000));
    cyc(OP_LW, 3'b000, 0, 0, 1, 0, "reset1", e_rst(3'b000));

    // lw, no wait states
    cyc(OP_LW, 3'b010, 0, 0, 1, 1, "lw_fetch",  e_fetch(1, 3'b000));
    cyc(OP_LW, 3'b010, 0, 0, 1, 1, "lw_decode", e_dec(3'b000));
    cyc(OP_LW, 3'b010, 0, 0, 1, 1, "lw_memadr", e_memadr(3'b000));
    cyc(OP_LW, 3'b010, 0, 0, 1, 1, "lw_memrd",  e_memrd(3'b000));
    cyc(OP_LW, 3'b010, 0, 0, 1, 1, "lw_memwb",  e_memwb(3'b000));

    // sw with 3 fetch wait cycles and 2 write wait cycles: 9 cycles total
    for (int i = 0; i < 3; i++) cyc(OP_SW, 3'b010, 0, 0, 0, 1, "sw_fetch_wait", e_fetch(0, 3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 1, 1, "sw_fetch",  e_fetch(1, 3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 0, 1, "sw_decode", e_dec(3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 0, 1, "sw_memadr", e_memadr(3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 0, 1, "sw_memwr_wait0", e_memwr(3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 0, 1, "sw_memwr_wait1", e_memwr(3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 1, 1, "sw_memwr_done", e_memwr(3'b001));

    // R-type sub
    cyc(OP_R, 3'b000, 1, 0, 1, 1, "sub_fetch",  e_fetch(1, 3'b000));
    cyc(OP_R, 3'b000, 1, 0, 1, 1, "sub_decode", e_dec(3'b000));
    cyc(OP_R, 3'b000, 1, 0, 1, 1, "sub_execr",  e_execr(3'b001, 3'b000));
    cyc(OP_R, 3'b000, 1, 0, 1, 1, "sub_aluwb",  e_aluwb(3'b000));

    // addi with funct7b5=1 must still add
    cyc(OP_IALU, 3'b000, 1, 0, 1, 1, "addi_fetch",  e_fetch(1, 3'b000));
    cyc(OP_IALU, 3'b000, 1, 0, 1, 1, "addi_decode", e_dec(3'b000));
    cyc(OP_IALU, 3'b000, 1, 0, 1, 1, "addi_execi",  e_execi(3'b000, 3'b000));
    cyc(OP_IALU, 3'b000, 1, 0, 1, 1, "addi_aluwb",  e_aluwb(3'b000));

    // slt, or, and, unsupported funct3
    cyc(OP_R, 3'b010, 0, 0, 1, 1, "slt_fetch",  e_fetch(1, 3'b000));
    cyc(OP_R, 3'b010, 0, 0, 1, 1, "slt_decode", e_dec(3'b000));
    cyc(OP_R, 3'b010, 0, 0, 1, 1, "slt_execr",  e_execr(3'b101, 3'b000));
    cyc(OP_R, 3'b010, 0, 0, 1, 1, "slt_aluwb",  e_aluwb(3'b000));
    cyc(OP_R, 3'b110, 0, 0, 1, 1, "or_fetch",   e_fetch(1, 3'b000));
    cyc(OP_R, 3'b110, 0, 0, 1, 1, "or_decode",  e_dec(3'b000));
    cyc(OP_R, 3'b110, 0, 0, 1, 1, "or_execr",   e_execr(3'b011, 3'b000));
    cyc(OP_R, 3'b110, 0, 0, 1, 1, "or_aluwb",   e_aluwb(3'b000));
    cyc(OP_IALU, 3'b111, 0, 0, 1, 1, "andi_fetch",  e_fetch(1, 3'b000));
    cyc(OP_IALU, 3'b111, 0, 0, 1, 1, "andi_decode", e_dec(3'b000));
    cyc(OP_IALU, 3'b111, 0, 0, 1, 1, "andi_execi",  e_execi(3'b010, 3'b000));
    cyc(OP_IALU, 3'b111, 0, 0, 1, 1, "andi_aluwb",  e_aluwb(3'b000));
    cyc(OP_R, 3'b001, 1, 0, 1, 1, "f3_001_fetch",  e_fetch(1, 3'b000));
    cyc(OP_R, 3'b001, 1, 0, 1, 1, "f3_001_decode", e_dec(3'b000));
    cyc(OP_R, 3'b001, 1, 0, 1, 1, "f3_001_execr",  e_execr(3'b000, 3'b000));
    cyc(OP_R, 3'b001, 1, 0, 1, 1, "f3_001_aluwb",  e_aluwb(3'b000));

    // beq taken then not taken, 3 cycles each
    cyc(OP_BEQ, 3'b000, 0, 1, 1, 1, "beq_t_fetch",  e_fetch(1, 3'b010));
    cyc(OP_BEQ, 3'b000, 0, 1, 1, 1, "beq_t_decode", e_dec(3'b010));
    cyc(OP_BEQ, 3'b000, 0, 1, 1, 1, "beq_t_beq",    e_beq(1, 3'b010));
    cyc(OP_BEQ, 3'b000, 0, 0, 1, 1, "beq_n_fetch",  e_fetch(1, 3'b010));
    cyc(OP_BEQ, 3'b000, 0, 0, 1, 1, "beq_n_decode", e_dec(3'b010));
    cyc(OP_BEQ, 3'b000, 0, 0, 1, 1, "beq_n_beq",    e_beq(0, 3'b010));

    // jal
    cyc(OP_JAL, 3'b000, 0, 0, 1, 1, "jal_fetch",  e_fetch(1, 3'b011));
    cyc(OP_JAL, 3'b000, 0, 0, 1, 1, "jal_decode", e_dec(3'b011));
    cyc(OP_JAL, 3'b000, 0, 0, 1, 1, "jal_jal",    e_jal(3'b011));
    cyc(OP_JAL, 3'b000, 0, 0, 1, 1, "jal_aluwb",  e_aluwb(3'b011));

    // lui
    cyc(OP_LUI, 3'b000, 0, 0, 1, 1, "lui_fetch",  e_fetch(1, 3'b100));
    cyc(OP_LUI, 3'b000, 0, 0, 1, 1, "lui_decode", e_dec(3'b100));
    cyc(OP_LUI, 3'b000, 0, 0, 1, 1, "lui_lui",    e_lui(3'b100));

    // reset pulsed in the middle of a stalled store
    cyc(OP_SW, 3'b010, 0, 0, 1, 1, "swr_fetch",  e_fetch(1, 3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 1, 1, "swr_decode", e_dec(3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 1, 1, "swr_memadr", e_memadr(3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 0, 1, "swr_memwr",  e_memwr(3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 1, 0, "swr_reset",  e_rst(3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 1, 1, "swr_after_fetch", e_fetch(1, 3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 1, 1, "swr_after_decode", e_dec(3'b001));

    // finish that store cleanly so the next fetch starts fresh
    cyc(OP_SW, 3'b010, 0, 0, 1, 1, "swr2_memadr", e_memadr(3'b001));
    cyc(OP_SW, 3'b010, 0, 0, 1, 1, "swr2_memwr",  e_memwr(3'b001));

    // unsupported opcode traps until reset
    cyc(OP_BAD, 3'b000, 0, 0, 1, 1, "bad_fetch",  e_fetch(1, 3'b000));
    cyc(OP_BAD, 3'b000, 0, 0, 1, 1, "bad_decode", e_dec(3'b000));
    for (int i = 0; i < 12; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      cyc(OP_BAD, 3'b000, 0, iv[0], iv[1], 1, "trap", e_trap(3'b000));
    end
    cyc(OP_LW, 3'b000, 0, 0, 1, 0, "trap_reset", e_rst(3'b000));
    cyc(OP_LW, 3'b000, 0, 0, 1, 1, "post_trap_fetch",  e_fetch(1, 3'b000));
    cyc(OP_LW, 3'b000, 0, 0, 1, 1, "post_trap_decode", e_dec(3'b000));

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ucsbece154a_mc_controller.md
Name: ucsbece154a_mc_controller

Overview:
- Multicycle RV32I-subset control FSM. Sequences a shared-memory datapath: one memory port, one ALU, instruction register (IR) and holding registers OldPC, A, ALUOut and Data.
- Decodes lw, sw, R-type (add/sub/and/or/slt), I-type ALU, beq, jal and lui.
- Stalls on a memory-ready handshake. Traps on unsupported opcodes.
- Sits beside the multicycle datapath in the processor top level, replacing the single-cycle decoder.

Parameters:
- NONE, -, opcodes and encodings are fixed by the defines header (lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111, lui 0110111)

Ports:
- clk  in  1  rising-edge clock
- reset_ni  in  1  asynchronous active-low reset
- op_i  in  7  IR[6:0]
- funct3_i  in  3  IR[14:12]
- funct7b5_i  in  1  IR[30]
- zero_i  in  1  ALU zero flag
- MemReady_i  in  1  memory completes the current access this cycle
- PCWrite_o  out  1  PC register enable
- AdrSrc_o  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite_o  out  1  memory write strobe
- IRWrite_o  out  1  IR and OldPC enable
- ResultSrc_o  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
- ALUSrcA_o  out  2  ALU A select: 00=PC, 01=OldPC, 10=A
- ALUSrcB_o  out  2  ALU B select: 00=WriteData, 01=ImmExt, 10=constant 4
- ALUControl_o  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite_o  out  1  register file write
- ImmSrc_o  out  3  immediate type: I 000, S 001, B 010, J 011, U 100
- Illegal_o  out  1  sticky unsupported-opcode flag

Behaviour:
- Output timing
  - State register is 4 bits. All outputs are combinational from state, op_i, funct3_i, funct7b5_i, zero_i and MemReady_i.
  - Unlisted selects are 0. Unlisted enables are 0.
- Reset
  - While reset_ni=0: state=FETCH; PCWrite_o, IRWrite_o, MemWrite_o and RegWrite_o are all forced to 0; Illegal_o=0.
  - Reset asserted mid-instruction aborts it immediately. There is no partial write after the reset edge.
- ImmSrc_o
  - Decoded from op_i in every state: lw and I-ALU → I; sw → S; beq → B; jal → J; lui → U.
  - Any other op → 000.
- ALU decoder
  - ALUOp=00 → add. ALUOp=01 → sub.
  - ALUOp=10 decodes funct3:
    - 000 → sub if (funct7b5_i & op_i[5]), else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - any other funct3 → 000
- States (output settings → next state)
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=MemReady_i. Next state is DECODE if MemReady_i, else stay in FETCH.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
    - lw or sw → MEMADR
    - R → EXECR
    - I-ALU → EXECI
    - beq → BEQ
    - jal → JAL
    - lui → LUI
    - any other op → TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1. Wait in MEMREAD while !MemReady_i, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1, held until MemReady_i. Next state FETCH on ready.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero_i. Next state FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next state ALUWB (rd = OldPC+4).
  - LUI: ResultSrc=11, RegWrite=1. Next state FETCH.
  - TRAP: all enables 0, Illegal_o=1. Stays in TRAP until reset.
- Cycle counts with zero memory wait: lw 5, sw 4, R/I 4, beq 3, jal 4, lui 3.
- Each memory wait cycle adds one cycle.
- State encodings outside the defined set → next state FETCH with all enables 0.

Test Plan:
- Reset released mid-MEMWRITE (reset_ni pulsed low) → MemWrite_o=0 immediately; next active state is FETCH; Illegal_o=0.
- lw, MemReady_i=1 always → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite_o=1 only in cycle 5, with ResultSrc_o=01 and ImmSrc_o=000.
- sw with MemReady_i low for 3 cycles in FETCH and 2 cycles in MEMWRITE → IRWrite_o and PCWrite_o pulse exactly once. MemWrite_o=1 for 3 consecutive cycles. Total 9 cycles.
- R-type sub (funct3=000, funct7b5=1) → ALUControl_o=001 in EXECR. The same funct3/funct7b5 on I-ALU (addi) → 000. funct3=010 → 101.
- beq with zero_i=1 → PCWrite_o=1 in BEQ; with zero_i=0 → 0. Both cases return to FETCH after 3 cycles.
- op=0001111 → DECODE→TRAP; Illegal_o=1 and all enables stay 0 for 10+ cycles. Asserting reset_ni=0 clears the trap.
